// File: rtl/mux_sel_scanner.sv
// Mux select sequencer: steps s1/s0 through channels 0..3 with a settle dwell,
// samples y on each channel and publishes the four samples as one word.
module mux_sel_scanner #(
   parameter int DWELL = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y,
   output logic       s1,
   output logic       s0,
   output logic       busy,
   output logic       done,
   output logic [3:0] word
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [7:0] LAST = 8'(DWELL - 1);

   state_t     state, state_n;
   logic [1:0] chan, chan_n;
   logic [7:0] cnt, cnt_n;
   logic [3:0] shadow, shadow_n;
   logic [3:0] word_n;
   logic [1:0] sel_n;
   logic       busy_n, done_n;

   always_comb begin
      state_n  = state;
      chan_n   = chan;
      cnt_n    = cnt;
      shadow_n = shadow;
      word_n   = word;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_SETTLE;
               chan_n  = 2'd0;
               cnt_n   = 8'd0;
            end
         end
         ST_SETTLE: begin
            cnt_n = cnt + 8'd1;
            if (cnt == LAST)
               state_n = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            shadow_n[chan] = y;
            if (chan == 2'd3) begin
               word_n  = {y, shadow[2:0]};
               state_n = ST_DONE;
            end else begin
               chan_n  = chan + 2'd1;
               cnt_n   = 8'd0;
               state_n = ST_SETTLE;
            end
         end
         ST_DONE: begin
            chan_n  = 2'd0;
            cnt_n   = 8'd0;
            state_n = start ? ST_SETTLE : ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they leave flops directly.
   always_comb begin
      busy_n = (state_n == ST_SETTLE) || (state_n == ST_SAMPLE);
      done_n = (state_n == ST_DONE);
      sel_n  = busy_n ? chan_n : 2'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         chan   <= 2'd0;
         cnt    <= 8'd0;
         shadow <= 4'b0000;
         word   <= 4'b0000;
         s1     <= 1'b0;
         s0     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         chan   <= chan_n;
         cnt    <= cnt_n;
         shadow <= shadow_n;
         word   <= word_n;
         s1     <= sel_n[1];
         s0     <= sel_n[0];
         busy   <= busy_n;
         done   <= done_n;
      end
   end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Scoreboard bench for mux_sel_scanner: two instances (DWELL=2 and DWELL=1)
// against an edge-arithmetic reference model of the scan timing.
module tb_mux_sel_scanner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_0, start_1;
   logic       y_0, y_1;
   logic       s1_0, s0_0, busy_0, done_0;
   logic       s1_1, s0_1, busy_1, done_1;
   logic [3:0] word_0, word_1;
   logic [3:0] in_vec [2];

   typedef struct {
      logic [3:0] w;
      int         e;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   done_edges0[$];

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   bit         active [2];
   int         acc [2];
   int         last_done [2];
   logic [3:0] samp [2];
   logic [3:0] exp_word [2];
   logic [1:0] exp_sel [2];
   bit         exp_busy [2];
   bit         exp_done [2];

   always #5 clk = ~clk;

   assign y_0 = in_vec[0][{s1_0, s0_0}];
   assign y_1 = in_vec[1][{s1_1, s0_1}];

   mux_sel_scanner #(.DWELL(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_0), .y(y_0),
      .s1(s1_0), .s0(s0_0), .busy(busy_0), .done(done_0), .word(word_0)
   );

   mux_sel_scanner #(.DWELL(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_1), .y(y_1),
      .s1(s1_1), .s0(s0_1), .busy(busy_1), .done(done_1), .word(word_1)
   );

   function automatic int dw(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic logic [7:0] outs(input int i);
      if (i == 0) return {s1_0, s0_0, busy_0, done_0, word_0};
      return {s1_1, s0_1, busy_1, done_1, word_1};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at edge %0d",
                  name, act, exp, cyc);
      end
   endtask

   // A start seen at edge e is taken unless a scan is still running; a scan
   // taken at edge a samples channel k at a+(k+1)(D+1) and ends at a+4(D+1).
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int d;
         int l;
         int off;
         int k;
         logic st;
         d  = dw(i);
         l  = 4 * (d + 1);
         st = (i == 0) ? start_0 : start_1;
         if (!rst_n) begin
            active[i]    = 1'b0;
            last_done[i] = -1000;
            exp_word[i]  = 4'b0000;
            exp_sel[i]   = 2'd0;
            exp_busy[i]  = 1'b0;
            exp_done[i]  = 1'b0;
         end else begin
            if (active[i]) begin
               off = cyc - acc[i];
               if (off > 0 && off % (d + 1) == 0) begin
                  k = off / (d + 1) - 1;
                  samp[i][k] = in_vec[i][k];
               end
               if (off == l) begin
                  active[i]    = 1'b0;
                  last_done[i] = cyc;
                  exp_word[i]  = samp[i];
                  if (i == 0) q0.push_back('{samp[i], cyc});
                  else        q1.push_back('{samp[i], cyc});
               end
            end
            if (!active[i] && st && cyc > last_done[i]) begin
               active[i] = 1'b1;
               acc[i]    = cyc;
            end
            if (active[i]) begin
               exp_sel[i]  = 2'((cyc - acc[i]) / (d + 1));
               exp_busy[i] = 1'b1;
               exp_done[i] = 1'b0;
            end else begin
               exp_sel[i]  = 2'd0;
               exp_busy[i] = 1'b0;
               exp_done[i] = (cyc == last_done[i]);
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            logic [7:0] o;
            exp_t       e;
            o = outs(i);
            chk($sformatf("sel%0d", i), int'(o[7:6]), int'(exp_sel[i]));
            chk($sformatf("busy%0d", i), int'(o[5]), int'(exp_busy[i]));
            chk($sformatf("done%0d", i), int'(o[4]), int'(exp_done[i]));
            chk($sformatf("word%0d", i), int'(o[3:0]), int'(exp_word[i]));
            if (o[4]) begin
               if (i == 0) done_edges0.push_back(cyc - 1);
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  chk($sformatf("spurious_done%0d", i), 1, 0);
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("sb_word%0d", i), int'(o[3:0]), int'(e.w));
                  chk($sformatf("sb_edge%0d", i), cyc - 1, e.e);
               end
            end
         end
      end
   end

   task automatic all_zero(input string tag);
      chk({tag, "_outs0"}, int'(outs(0)), 0);
      chk({tag, "_outs1"}, int'(outs(1)), 0);
   endtask

   task automatic pulse(input bit a, input bit b);
      start_0 = a;
      start_1 = b;
      @(negedge clk);
      start_0 = 1'b0;
      start_1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      start_0   = 1'b0;
      start_1   = 1'b0;
      in_vec[0] = 4'b0000;
      in_vec[1] = 4'b0000;
      #3;
      all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      all_zero("idle");

      // basic scan, i0..i3 = 0,1,0,1
      in_vec[0] = 4'b1010;
      in_vec[1] = 4'b1010;
      done_edges0.delete();
      pulse(1'b1, 1'b1);
      repeat (20) @(negedge clk);
      chk("basic_word0", int'(word_0), 4'b1010);
      chk("basic_word1", int'(word_1), 4'b1010);
      chk("basic_ndone", done_edges0.size(), 1);

      // word hold across a scan with all-zero inputs
      in_vec[0] = 4'b0000;
      pulse(1'b1, 1'b0);
      repeat (6) @(negedge clk);
      chk("hold_word", int'(word_0), 4'b1010);
      repeat (12) @(negedge clk);
      chk("hold_after", int'(word_0), 4'b0000);

      // back-to-back, inputs change during channel-0 settle
      in_vec[0] = 4'b1010;
      done_edges0.delete();
      start_0 = 1'b1;
      @(negedge clk);
      in_vec[0] = 4'b0011;
      repeat (25) @(negedge clk);
      start_0 = 1'b0;
      repeat (20) @(negedge clk);
      chk("b2b_word", int'(word_0), 4'b0011);
      chk("b2b_ndone", done_edges0.size(), 2);
      if (done_edges0.size() == 2)
         chk("b2b_gap", done_edges0[1] - done_edges0[0], 13);

      // start while busy is ignored
      in_vec[0] = 4'b0101;
      done_edges0.delete();
      pulse(1'b1, 1'b0);
      repeat (4) @(negedge clk);
      pulse(1'b1, 1'b0);
      repeat (20) @(negedge clk);
      chk("busy_ndone", done_edges0.size(), 1);
      chk("busy_word", int'(word_0), 4'b0101);

      // reset mid-scan while select = 10
      in_vec[0] = 4'b1111;
      done_edges0.delete();
      pulse(1'b1, 1'b0);
      n = 0;
      while (!(s1_0 && !s0_0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_sel2", int'(n < 40), 1);
      #2;
      rst_n = 1'b0;
      #1;
      all_zero("rst_mid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_ndone", done_edges0.size(), 0);
      repeat (3) @(negedge clk);
      in_vec[0] = 4'b0110;
      pulse(1'b1, 1'b0);
      repeat (20) @(negedge clk);
      chk("rst_rescan", int'(word_0), 4'b0110);

      // randomized traffic on both instances
      repeat (400) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            if ($urandom_range(0, 2) == 0)
               in_vec[i] = 4'($urandom);
         start_0 = ($urandom_range(0, 3) == 0);
         start_1 = ($urandom_range(0, 3) == 0);
      end
      start_0 = 1'b0;
      start_1 = 1'b0;
      repeat (30) @(negedge clk);
      chk("sb_empty0", q0.size(), 0);
      chk("sb_empty1", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
